// File: rtl/wb_router_pkg.sv
// wb_router_pkg: shared types and helpers for wb_slave_router.
// Holds the router state enum, the unmapped-read filler word and the base-code decoder.
package wb_router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [31:0] DEAD_WORD = 32'hDEAD_BEEF;
  localparam int MAX_SLV = 8;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } dec_t;

  // Walks downward so the lowest matching index is the one left standing.
  function automatic dec_t decode(
    input logic [7:0]           code,
    input logic [8*MAX_SLV-1:0] base,
    input int                   n_slv
  );
    dec_t d;
    d = '0;
    for (int i = MAX_SLV - 1; i >= 0; i--) begin
      if (i < n_slv && base[8*i +: 8] == code) begin
        d.hit = 1'b1;
        d.idx = 3'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/wb_router_timer.sv
// wb_router_timer: BUSY-cycle watchdog for the router.
// Ports: clk, rst (async, high), clr, en; expire is high on the TIMEOUT_CYC-th enabled cycle.
module wb_router_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LIM = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  // cnt holds the number of BUSY cycles already spent, so this
  // fires on the cycle that would be number TIMEOUT_CYC.
  assign expire = en && (cnt == LIM);

endmodule

// File: rtl/wb_slave_router.sv
// wb_slave_router: Wishbone classic 1-to-N_SLV address router with registered response,
// hung-slave timeout and self-answered unmapped cycles. Optional macro: WB_ROUTER_ERR_EN.
// Ports: wbs_* master side (clk, async high rst, stb/cyc/we/sel/adr/dat in; ack/err/dat out),
// s_* slave side (one-hot stb/cyc, shared we/sel/adr/dat out; per-slave ack and dat in).
module wb_slave_router
  import wb_router_pkg::*;
#(
  parameter int               N_SLV       = 4,
  parameter int               DW          = 32,
  parameter int               AW          = 32,
  parameter int               DEC_MSB     = 31,
  parameter int               DEC_LSB     = 24,
  parameter logic [8*N_SLV-1:0] SLV_BASE  = 32'h3C38_3430,
  parameter int               TIMEOUT_CYC = 255
) (
  input  logic                wbs_clk_i,
  input  logic                wbs_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [DW/8-1:0]     wbs_sel_i,
  input  logic [AW-1:0]       wbs_adr_i,
  input  logic [DW-1:0]       wbs_dat_i,
  output logic                wbs_ack_o,
  output logic                wbs_err_o,
  output logic [DW-1:0]       wbs_dat_o,
  output logic [N_SLV-1:0]    s_stb_o,
  output logic [N_SLV-1:0]    s_cyc_o,
  output logic                s_we_o,
  output logic [DW/8-1:0]     s_sel_o,
  output logic [AW-1:0]       s_adr_o,
  output logic [DW-1:0]       s_dat_o,
  input  logic [N_SLV-1:0]    s_ack_i,
  input  logic [N_SLV*DW-1:0] s_dat_i
);

`ifdef WB_ROUTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [N_SLV-1:0] stb_d;
  logic [2:0]       idx_q, idx_d;
  logic             miss_q, miss_d;
  logic             latch;
  logic             ack_d, err_d;
  logic [DW-1:0]    dat_d;
  logic [DW-1:0]    rd_dat;
  logic             sel_ack;
  logic             tmr_clr, tmr_en, tmr_exp;
  logic [7:0]       code;
  dec_t             dec;

  assign code    = 8'(wbs_adr_i[DEC_MSB:DEC_LSB]);
  assign dec     = decode(code, 64'(SLV_BASE), N_SLV);
  assign s_cyc_o = s_stb_o;
  // Masking with s_stb_o drops acks from unselected slaves and
  // any ack outside BUSY, where s_stb_o is zero.
  assign sel_ack = |(s_ack_i & s_stb_o);

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (idx_q == 3'(i)) rd_dat = s_dat_i[DW*i +: DW];
    end
  end

  wb_router_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (wbs_clk_i),
    .rst   (wbs_rst_i),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(tmr_exp)
  );

  // Unmapped cycles also pass through one strobe-less BUSY cycle,
  // so a miss answers at the same latency as a zero-wait slave.
  always_comb begin
    state_d = state_q;
    stb_d   = s_stb_o;
    idx_d   = idx_q;
    miss_d  = miss_q;
    latch   = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = wbs_dat_o;
    tmr_clr = 1'b1;
    tmr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wbs_stb_i && wbs_cyc_i) begin
          latch   = 1'b1;
          state_d = BUSY;
          idx_d   = dec.idx;
          miss_d  = !dec.hit;
          if (dec.hit) stb_d = N_SLV'(1) << dec.idx;
        end
      end
      BUSY: begin
        tmr_clr = 1'b0;
        tmr_en  = !miss_q;
        if (!wbs_cyc_i) begin
          stb_d   = '0;
          state_d = IDLE;
        end else if (sel_ack) begin
          stb_d   = '0;
          state_d = RESP;
          ack_d   = 1'b1;
          if (!s_we_o) dat_d = rd_dat;
        end else if (miss_q || tmr_exp) begin
          stb_d   = '0;
          state_d = RESP;
          if (ERR_EN) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (!s_we_o) dat_d = DW'(DEAD_WORD);
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge wbs_clk_i or posedge wbs_rst_i) begin
    if (wbs_rst_i) begin
      state_q   <= IDLE;
      s_stb_o   <= '0;
      idx_q     <= '0;
      miss_q    <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      s_we_o    <= 1'b0;
      s_sel_o   <= '0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
    end else begin
      state_q   <= state_d;
      s_stb_o   <= stb_d;
      idx_q     <= idx_d;
      miss_q    <= miss_d;
      wbs_ack_o <= ack_d;
      wbs_err_o <= err_d;
      wbs_dat_o <= dat_d;
      if (latch) begin
        s_we_o  <= wbs_we_i;
        s_sel_o <= wbs_sel_i;
        s_adr_o <= wbs_adr_i;
        s_dat_o <= wbs_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_router.sv
// tb_wb_slave_router: randomized self-checking bench for wb_slave_router.
// Expected routing, latency and response data come from an address-table model.
module tb_wb_slave_router;

  localparam int TO = 8;
`ifdef WB_ROUTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]   sel = '0;
  logic [31:0]  adr = '0, wdat = '0;
  logic         ack, err;
  logic [31:0]  rdat;
  logic [3:0]   s_stb, s_cyc;
  logic         s_we;
  logic [3:0]   s_sel;
  logic [31:0]  s_adr, s_dat;
  logic [3:0]   s_ack = '0;
  logic [127:0] s_dat_i = '0;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          in_resp = 1'b0;
  logic [31:0] exp_dat = '0;
  logic [7:0]  base[4] = '{8'h30, 8'h34, 8'h38, 8'h3C};
  logic [31:0] slv_dat[4];

  always #5 clk = ~clk;

  wb_slave_router #(
    .TIMEOUT_CYC(TO)
  ) dut (
    .wbs_clk_i(clk),
    .wbs_rst_i(rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_err_o(err),
    .wbs_dat_o(rdat),
    .s_stb_o  (s_stb),
    .s_cyc_o  (s_cyc),
    .s_we_o   (s_we),
    .s_sel_o  (s_sel),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_dat),
    .s_ack_i  (s_ack),
    .s_dat_i  (s_dat_i)
  );

  // One master cycle against a slave that acks dly cycles after its strobe
  // appears (dly >= TO means it never acks in time). hold keeps stb high.
  task automatic run_txn(input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s,
                         input int dly, input logic [3:0] stray,
                         input bit hold);
    bit hit;
    bit ok;
    int idx, rc, off, k;
    logic [3:0] oh, e_stb;
    logic e_ack, e_err;
    logic [31:0] nd;
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      if (!hit && a[31:24] == base[i]) begin
        hit = 1'b1;
        idx = i;
      end
    end
    oh = hit ? 4'(1 << idx) : 4'b0;
    if (!hit) begin
      rc = 2; ok = 1'b0;
    end else if (dly < TO) begin
      rc = dly + 2; ok = 1'b1;
    end else begin
      rc = TO + 1; ok = 1'b0;
    end
    nd = exp_dat;
    if (!w) begin
      if (ok) nd = slv_dat[idx];
      else if (!ERR_EN) nd = 32'hDEAD_BEEF;
    end
    off = in_resp ? 1 : 0;
    s_dat_i = {slv_dat[3], slv_dat[2], slv_dat[1], slv_dat[0]};
    stb = 1'b1; cyc = 1'b1; adr = a; we = w; wdat = d; sel = s;
    s_ack = stray;
    for (int c = 1; c <= rc + off; c++) begin
      @(posedge clk); #1;
      k = c - off;
      e_stb = (k >= 1 && k < rc) ? oh : 4'b0;
      e_ack = (k == rc) && (ok || !ERR_EN);
      e_err = (k == rc) && !ok && ERR_EN;
      n_chk++;
      if ({s_stb, s_cyc} !== {e_stb, e_stb}) begin
        n_fail++;
        $display("FAIL strobe a=%h k=%0d: got %b/%b want %b", a, k, s_stb, s_cyc, e_stb);
      end
      n_chk++;
      if ({ack, err} !== {e_ack, e_err}) begin
        n_fail++;
        $display("FAIL ack_err a=%h k=%0d: got %b%b want %b%b", a, k, ack, err, e_ack, e_err);
      end
      if (k == 1) begin
        n_chk++;
        if ({s_adr, s_dat, s_sel, s_we} !== {a, d, s, w}) begin
          n_fail++;
          $display("FAIL latch a=%h: got %h %h %h %b want %h %h %h %b",
                   a, s_adr, s_dat, s_sel, s_we, a, d, s, w);
        end
      end
      if (k == rc) begin
        exp_dat = nd;
        n_chk++;
        if (rdat !== exp_dat) begin
          n_fail++;
          $display("FAIL rdata a=%h: got %h want %h", a, rdat, exp_dat);
        end
      end
      s_ack = stray | ((k >= 1 && k - 1 == dly && k < rc) ? oh : 4'b0);
    end
    s_ack = '0;
    if (hold) begin
      in_resp = 1'b1;
    end else begin
      stb = 1'b0; cyc = 1'b0;
      @(posedge clk); #1;
      in_resp = 1'b0;
      n_chk++;
      if ({ack, err, s_stb} !== 6'b0 || rdat !== exp_dat) begin
        n_fail++;
        $display("FAIL idle_after a=%h: got %b%b %b %h want 00 0000 %h",
                 a, ack, err, s_stb, rdat, exp_dat);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({ack, err, s_we, s_stb, s_cyc, s_sel} !== 15'b0 ||
        rdat !== 32'b0 || s_adr !== 32'b0 || s_dat !== 32'b0) begin
      n_fail++;
      $display("FAIL reset: got %b%b%b %b %b %h %h %h %h want all zero",
               ack, err, s_we, s_stb, s_cyc, s_sel, rdat, s_adr, s_dat);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    slv_dat[0] = $urandom; slv_dat[1] = 32'h1234_5678;
    slv_dat[2] = $urandom; slv_dat[3] = $urandom;
    run_txn(32'h3400_0010, 1'b0, 32'h0, 4'hF, 1, 4'b0, 1'b0);
    run_txn(32'h3000_0020, 1'b0, 32'h0, 4'hF, 0, 4'b0, 1'b0);
  endtask

  task automatic test_write();
    run_txn(32'h3000_0004, 1'b1, 32'hA5A5_A5A5, 4'hF, 3, 4'b0, 1'b0);
  endtask

  task automatic test_unmapped();
    run_txn(32'h5000_0000, 1'b0, 32'h0, 4'hF, 0, 4'b0, 1'b0);
    run_txn(32'h5000_0008, 1'b1, 32'h1, 4'h3, 0, 4'b0, 1'b0);
  endtask

  task automatic test_timeout();
    slv_dat[2] = $urandom;
    run_txn(32'h3800_0000, 1'b0, 32'h0, 4'hF, TO + 5, 4'b0, 1'b0);
    slv_dat[2] = $urandom;
    run_txn(32'h3800_0040, 1'b0, 32'h0, 4'hF, TO - 1, 4'b0, 1'b0);
  endtask

  task automatic test_abort();
    stb = 1'b1; cyc = 1'b1; adr = 32'h3800_0000; we = 1'b0;
    s_ack = '0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      n_chk++;
      if (s_stb !== ((c <= 2) ? 4'b0100 : 4'b0000) || {ack, err} !== 2'b0 ||
          rdat !== exp_dat) begin
        n_fail++;
        $display("FAIL abort c=%0d: got %b %b%b %h want %b 00 %h", c, s_stb,
                 ack, err, rdat, (c <= 2) ? 4'b0100 : 4'b0000, exp_dat);
      end
      if (c == 2) begin
        stb = 1'b0; cyc = 1'b0;
      end
    end
  endtask

  task automatic test_rst_mid();
    stb = 1'b1; cyc = 1'b1; adr = 32'h3C00_0000; we = 1'b1;
    wdat = 32'hCAFE_F00D; sel = 4'h5;
    @(posedge clk); #1;
    n_chk++;
    if (s_stb !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got %b want 1000", s_stb);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({ack, err, s_we, s_stb, s_cyc, s_sel} !== 15'b0 ||
        rdat !== 32'b0 || s_adr !== 32'b0 || s_dat !== 32'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got %b %b %h %h %h want all zero",
               s_stb, s_sel, rdat, s_adr, s_dat);
    end
    exp_dat = '0;
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if ({ack, err, s_stb} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_mid_post: got %b%b %b want 00 0000", ack, err, s_stb);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) slv_dat[i] = $urandom;
    run_txn(32'h3800_0000, 1'b0, 32'h0, 4'hF, 0, 4'b0, 1'b1);
    run_txn(32'h3C00_0000, 1'b0, 32'h0, 4'hF, 2, 4'b0001, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0] stray;
    int r;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) slv_dat[i] = $urandom;
      r = $urandom_range(0, 4);
      a = $urandom;
      a[31:24] = (r < 4) ? base[r] : (8'h40 | 8'($urandom_range(0, 15)));
      stray = 4'($urandom_range(0, 15));
      if (r < 4) stray[r] = 1'b0;
      run_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 10), stray, 1'($urandom_range(0, 1)));
    end
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_resp = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) slv_dat[i] = '0;
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_timeout();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
